mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM state encoding,
// access-length encoding and a helper that turns a length code into a byte count.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    // Byte count of an access; both 10 and 11 mean a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: len_bytes = 3'd1;
            LEN_HALF: len_bytes = 3'd2;
            default:  len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller arbitrating an instruction-fetch port and a load/store port
// onto a byte-wide synchronous RAM. Multi-byte accesses are sequenced one byte
// per cycle, little-endian, with the address wrapping at the top of the space.
//
// Handshake: a requester raises req with stable operands and keeps them stable
// until its done pulse (one cycle, in DONE). The DONE cycle sits between every
// completion and the next accept, so a req still high in DONE is not taken twice.
// The fetch side may drop a fetch in flight with if_cancel; nothing else preempts.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [1:0]        mem_len,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_we,
    input  logic [7:0]        ram_din,
    output logic              busy,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output state_t            dbg_state
);

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_cnt;
    logic [2:0]        r_nbytes;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_is_if;
    logic [31:0]       r_asm;
    logic [31:0]       r_if_inst;
    logic [31:0]       r_mem_rdata;
    logic [1:0]        w_bidx;
    logic [31:0]       w_asm_next;

    // Byte lane that the RAM data arriving this cycle belongs to (issued one cycle ago).
    assign w_bidx     = r_cnt[1:0] - 2'd1;
    assign w_asm_next = r_asm | ({24'd0, ram_din} << {w_bidx, 3'b000});

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state and RAM-side outputs; RAM lines are quiet outside transfers.
    always_comb begin
        w_next   = r_state;
        ram_a    = '0;
        ram_dout = 8'd0;
        ram_we   = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req)                    w_next = mem_we ? MEM_WR : MEM_RD;
                else if (if_req && !if_cancel)  w_next = IF_RD;
            end
            IF_RD: begin
                ram_a = r_addr + ADDR_W'(r_cnt);
                if (if_cancel)                  w_next = IDLE;
                else if (r_cnt == r_nbytes)     w_next = DONE;
            end
            MEM_RD: begin
                ram_a = r_addr + ADDR_W'(r_cnt);
                if (r_cnt == r_nbytes)          w_next = DONE;
            end
            MEM_WR: begin
                ram_a  = r_addr + ADDR_W'(r_cnt);
                ram_we = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    ram_dout = r_wdata[7:0];
                    2'd1:    ram_dout = r_wdata[15:8];
                    2'd2:    ram_dout = r_wdata[23:16];
                    default: ram_dout = r_wdata[31:24];
                endcase
                if (r_cnt == r_nbytes - 3'd1)   w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, step the byte counter, assemble read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= 3'd0;
            r_nbytes    <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_is_if     <= 1'b0;
            r_asm       <= 32'd0;
            r_if_inst   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 3'd0;
                    r_asm <= 32'd0;
                    if (mem_req) begin
                        r_addr   <= mem_addr;
                        r_nbytes <= len_bytes(mem_len);
                        r_wdata  <= mem_wdata;
                        r_is_if  <= 1'b0;
                    end else if (if_req && !if_cancel) begin
                        r_addr   <= if_addr;
                        r_nbytes <= 3'd4;
                        r_is_if  <= 1'b1;
                    end
                end
                IF_RD, MEM_RD: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt != 3'd0) r_asm <= w_asm_next;
                    if (w_next == DONE) begin
                        if (r_is_if) r_if_inst   <= w_asm_next;
                        else         r_mem_rdata <= w_asm_next;
                    end
                end
                MEM_WR:  r_cnt <= r_cnt + 3'd1;
                default: r_cnt <= 3'd0;
            endcase
        end
    end

    assign if_done      = (r_state == DONE) &&  r_is_if;
    assign mem_done     = (r_state == DONE) && !r_is_if;
    assign if_inst      = r_if_inst;
    assign mem_rdata    = r_mem_rdata;
    assign busy         = (r_state != IDLE);
    // Stall requests follow the requesters directly; held low while in reset.
    assign stallreq_if  = rst & if_req  & ~if_done;
    assign stallreq_mem = rst & mem_req & ~mem_done;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, shadow memory as reference, directed
// scenarios followed by randomized fetch/load/store traffic.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_cancel = 1'b0, if_done;
  logic [31:0] if_addr = 32'd0, if_inst;
  logic        mem_req = 1'b0, mem_we = 1'b0, mem_done;
  logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0, mem_rdata;
  logic [1:0]  mem_len = 2'b00;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic        busy, stallreq_if, stallreq_mem;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_if_inst   = 32'd0;
  logic [31:0] exp_mem_rdata = 32'd0;

  // RAM model storage (low 16 address bits) and the reference shadow copy.
  logic [7:0] ram_mem  [65536];
  bit         ram_wr   [65536];
  logic [7:0] shadow   [65536];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_len(mem_len),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we), .ram_din(ram_din),
    .busy(busy), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Power-up RAM contents: a fixed word at 0x100, a hash pattern elsewhere.
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h0100: init_byte = 8'h13;
      16'h0101: init_byte = 8'h57;
      16'h0102: init_byte = 8'h9B;
      16'h0103: init_byte = 8'hDF;
      default:  init_byte = a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [15:0] a);
    ram_rd = ram_wr[a] ? ram_mem[a] : init_byte(a);
  endfunction

  // Byte RAM: write on the edge, read data one cycle after the address.
  always @(posedge clk) begin
    ram_din <= ram_rd(ram_a[15:0]);
    if (ram_we) begin
      ram_mem[ram_a[15:0]] <= ram_dout;
      ram_wr[ram_a[15:0]]  <= 1'b1;
    end
  end

  function automatic int len_n(input logic [1:0] l);
    if (l == 2'b00)      len_n = 1;
    else if (l == 2'b01) len_n = 2;
    else                 len_n = 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // driver tasks (called at a negedge in an IDLE cycle)
  task automatic start_if(input logic [31:0] a);
    if_addr = a;
    if_req  = 1'b1;
  endtask

  task automatic start_mem(input bit we, input logic [31:0] a, input logic [1:0] len,
                           input logic [31:0] wd);
    mem_we    = we;
    mem_addr  = a;
    mem_len   = len;
    mem_wdata = wd;
    mem_req   = 1'b1;
  endtask

  // Follows one transfer accepted on the next rising edge: each read issues n
  // addresses then waits one more cycle for the last byte; a write drives n
  // bytes; then one done cycle, then IDLE. Ends at the negedge of that IDLE cycle.
  task automatic expect_xfer(input bit is_if, input bit we, input logic [31:0] addr,
                             input int n, input logic [31:0] wdata, input bit cancel_at_done);
    logic [31:0] exp_v;
    logic [31:0] a;
    logic [31:0] sh;
    int          done_c;
    exp_v = 32'd0;
    if (!we) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        exp_v = exp_v | ({24'd0, shadow[a[15:0]]} << (8 * k));
      end
    end
    done_c = we ? n + 1 : n + 2;
    for (int c = 1; c <= done_c; c++) begin
      @(posedge clk);
      if (cancel_at_done && c == done_c) begin
        #1;
        if_cancel = 1'b1;
      end
      @(negedge clk);
      check1("busy", busy, 1'b1);
      if (c <= n) begin
        a = addr + 32'(c - 1);
        check("ram_a", ram_a, a);
        check1("ram_we", ram_we, we);
        if (we) begin
          sh = wdata >> (8 * (c - 1));
          check("ram_dout", {24'd0, ram_dout}, {24'd0, sh[7:0]});
        end
      end else begin
        check1("ram_we_off", ram_we, 1'b0);
      end
      if (c == done_c) begin
        if (is_if)    exp_if_inst   = exp_v;
        else if (!we) exp_mem_rdata = exp_v;
      end
      check1("if_done", if_done, is_if && (c == done_c));
      check1("mem_done", mem_done, !is_if && (c == done_c));
      check("if_inst", if_inst, exp_if_inst);
      check("mem_rdata", mem_rdata, exp_mem_rdata);
      if (is_if) check1("stallreq_if", stallreq_if, c != done_c);
      else       check1("stallreq_mem", stallreq_mem, c != done_c);
    end
    if (is_if) if_req = 1'b0;
    else       mem_req = 1'b0;
    if_cancel = 1'b0;
    if (we) begin
      for (int k = 0; k < n; k++) begin
        a  = addr + 32'(k);
        sh = wdata >> (8 * k);
        shadow[a[15:0]] = sh[7:0];
      end
    end
    @(negedge clk);
    check1("idle_busy", busy, 1'b0);
    check("idle_ram_a", ram_a, 32'd0);
    check("idle_ram_dout", {24'd0, ram_dout}, 32'd0);
    check1("idle_ram_we", ram_we, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    logic [1:0]  rl;
    int          kind;

    for (int i = 0; i < 65536; i++) shadow[i] = init_byte(16'(i));

    // reset: every output low, requests ignored
    if_req  = 1'b1;
    mem_req = 1'b1;
    repeat (2) @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_if_done", if_done, 1'b0);
    check1("rst_mem_done", mem_done, 1'b0);
    check1("rst_ram_we", ram_we, 1'b0);
    check1("rst_stall_if", stallreq_if, 1'b0);
    check1("rst_stall_mem", stallreq_mem, 1'b0);
    check("rst_ram_a", ram_a, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    if_req  = 1'b0;
    mem_req = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check1("post_rst_idle", busy, 1'b0);

    // word fetch at 0x100
    start_if(32'h100);
    expect_xfer(1'b1, 1'b0, 32'h100, 4, 32'd0, 1'b0);
    check("fetch_0x100", if_inst, 32'hDF9B5713);

    // simultaneous fetch and word load: load first, one IDLE cycle, then fetch
    start_if(32'h104);
    start_mem(1'b0, 32'h200, 2'b10, 32'd0);
    expect_xfer(1'b0, 1'b0, 32'h200, 4, 32'd0, 1'b0);
    expect_xfer(1'b1, 1'b0, 32'h104, 4, 32'd0, 1'b0);

    // halfword store across 0x3FF/0x400, then read it back
    start_mem(1'b1, 32'h3FF, 2'b01, 32'hAABBCCDD);
    expect_xfer(1'b0, 1'b1, 32'h3FF, 2, 32'hAABBCCDD, 1'b0);
    start_mem(1'b0, 32'h3FF, 2'b01, 32'd0);
    expect_xfer(1'b0, 1'b0, 32'h3FF, 2, 32'd0, 1'b0);
    check("half_readback", mem_rdata, 32'h0000CCDD);

    // cancel in the third fetch cycle, with a byte load queued behind it
    start_if(32'h500);
    @(negedge clk);
    check("cancel_c1_ram_a", ram_a, 32'h500);
    @(negedge clk);
    start_mem(1'b0, 32'h600, 2'b00, 32'd0);
    @(negedge clk);
    check("cancel_c3_ram_a", ram_a, 32'h502);
    if_cancel = 1'b1;
    @(negedge clk);
    check1("cancel_idle", busy, 1'b0);
    check1("cancel_no_done", if_done, 1'b0);
    check("cancel_inst_held", if_inst, exp_if_inst);
    if_cancel = 1'b0;
    if_req    = 1'b0;
    expect_xfer(1'b0, 1'b0, 32'h600, 1, 32'd0, 1'b0);

    // cancel raised during the done cycle must not hide the done pulse
    start_if(32'h700);
    expect_xfer(1'b1, 1'b0, 32'h700, 4, 32'd0, 1'b1);

    // word load wrapping past the top of the address space
    start_mem(1'b0, 32'hFFFFFFFE, 2'b11, 32'd0);
    expect_xfer(1'b0, 1'b0, 32'hFFFFFFFE, 4, 32'd0, 1'b0);

    // reset in the middle of a word store: only the first byte lands
    start_mem(1'b1, 32'h800, 2'b10, 32'h11223344);
    @(negedge clk);
    check1("pre_rst_we", ram_we, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check1("midrst_ram_we", ram_we, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_mem_done", mem_done, 1'b0);
    shadow[16'h0800] = 8'h44;
    exp_if_inst   = 32'd0;
    exp_mem_rdata = 32'd0;
    mem_req = 1'b0;
    @(negedge clk);
    check1("midrst_no_done", mem_done, 1'b0);
    check("midrst_rdata", mem_rdata, 32'd0);
    check("midrst_inst", if_inst, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check1("midrst_idle", busy, 1'b0);
    start_mem(1'b0, 32'h800, 2'b10, 32'd0);
    expect_xfer(1'b0, 1'b0, 32'h800, 4, 32'd0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) ra = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else                           ra = 32'h1000 + 32'($urandom_range(0, 40));
      rl = 2'($urandom_range(0, 3));
      rd = $urandom;
      if (kind == 0) begin
        start_if(ra);
        expect_xfer(1'b1, 1'b0, ra, 4, 32'd0, 1'b0);
      end else begin
        start_mem(kind == 2, ra, rl, rd);
        expect_xfer(1'b0, kind == 2, ra, len_n(rl), rd, 1'b0);
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check1("gap_idle", busy, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
